recv_frame: RTL and testbench

Receive-side framer paired with the GTP transmit framer on the opposite link end. It parses the 2-word frames arriving from the GTP receiver (K-char head plus one payload word) and checks the 8-bit checksum. Data frames are written into the local rx buffer with duplicate suppression, and each data frame produces an ack/nack for the local transmit framer. Control frames are decoded into peer queue status and ack information (send_info) for the local transmit framer.

---
 rtl/recv_frame.sv | 224 ++++++++++++++++++++++
 tb/tb_recv_frame.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/recv_frame.sv
// Receive-side framer: parses 2-word K-char frames from the GTP receiver, checks the
// 8-bit checksum, writes data payloads to the rx buffer and decodes control frames.

module recv_frame #(
   parameter logic [7:0] K_CHAR    = 8'hBC,
   parameter logic [7:0] TYPE_DATA = 8'h55,
   parameter logic [7:0] TYPE_CTRL = 8'hAA,
   parameter int         ERR_CNT_W = 16
) (
   input  logic                 rx_clk,
   input  logic                 ap_rst_n,
   input  logic [31:0]          gtp_rxdata,
   input  logic [3:0]           gtp_rxctl,
   input  logic                 rx_allow,
   output logic                 rx_wren,
   output logic [31:0]          rx_wrdata,
   output logic                 send_back_flag,
   output logic [15:0]          send_back_data,
   output logic                 send_info_vaild,
   output logic [15:0]          send_info,
   output logic                 peer_statue_vaild,
   output logic [15:0]          peer_statue,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

   // Frame checksum: high-middle byte plus low byte of the payload, mod 256.
   function automatic logic [7:0] frame_sum(input logic [31:0] payload);
      frame_sum = payload[23:16] + payload[7:0];
   endfunction

   state_t                 state_r, state_s;
   logic [7:0]             type_r, type_s;
   logic [7:0]             sum_r, sum_s;
   logic [7:0]             seq_r, seq_s;
   logic [31:0]            payload_r, payload_s;
   logic [7:0]             last_seq_r, last_seq_s;
   logic                   last_seq_valid_r, last_seq_valid_s;
   logic                   rx_wren_r, rx_wren_s;
   logic [31:0]            rx_wrdata_r, rx_wrdata_s;
   logic                   send_back_flag_r, send_back_flag_s;
   logic [15:0]            send_back_data_r, send_back_data_s;
   logic                   send_info_vaild_r, send_info_vaild_s;
   logic [15:0]            send_info_r, send_info_s;
   logic                   peer_statue_vaild_r, peer_statue_vaild_s;
   logic [15:0]            peer_statue_r, peer_statue_s;
   logic [ERR_CNT_W-1:0]   err_cnt_r, err_cnt_s;
   logic                   err_inc_s;
   logic                   ack_ok_s;
   logic                   head_s;
   logic                   sum_ok_s;
   logic                   dup_s;

   assign head_s   = (gtp_rxctl == 4'b0001) && (gtp_rxdata[7:0] == K_CHAR);
   assign sum_ok_s = (frame_sum(payload_r) == sum_r);
   assign dup_s    = last_seq_valid_r && (seq_r == last_seq_r);

   // Next-state, frame evaluation and next output values.
   always_comb begin
      state_s             = state_r;
      type_s              = type_r;
      sum_s               = sum_r;
      seq_s               = seq_r;
      payload_s           = payload_r;
      last_seq_s          = last_seq_r;
      last_seq_valid_s    = last_seq_valid_r;
      rx_wren_s           = 1'b0;
      rx_wrdata_s         = rx_wrdata_r;
      send_back_flag_s    = 1'b0;
      send_back_data_s    = send_back_data_r;
      send_info_vaild_s   = 1'b0;
      send_info_s         = send_info_r;
      peer_statue_vaild_s = 1'b0;
      peer_statue_s       = peer_statue_r;
      err_inc_s           = 1'b0;
      ack_ok_s            = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (head_s) begin
               type_s  = gtp_rxdata[15:8];
               sum_s   = gtp_rxdata[23:16];
               seq_s   = gtp_rxdata[31:24];
               state_s = ST_PAYLOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_PAYLOAD: begin
            if (gtp_rxctl == 4'b0000) begin
               payload_s = gtp_rxdata;
               state_s   = ST_CHECK;
            end else if (head_s) begin
               // A new head aborts the current frame; restart from it.
               err_inc_s = 1'b1;
               type_s    = gtp_rxdata[15:8];
               sum_s     = gtp_rxdata[23:16];
               seq_s     = gtp_rxdata[31:24];
               state_s   = ST_PAYLOAD;
            end else begin
               err_inc_s = 1'b1;
               state_s   = ST_IDLE;
            end
         end

         ST_CHECK: begin
            if (type_r == TYPE_DATA) begin
               send_back_flag_s = 1'b1;
               if (sum_ok_s) begin
                  if (dup_s) begin
                     ack_ok_s = 1'b1;
                  end else if (rx_allow) begin
                     rx_wren_s        = 1'b1;
                     rx_wrdata_s      = payload_r;
                     last_seq_s       = seq_r;
                     last_seq_valid_s = 1'b1;
                     ack_ok_s         = 1'b1;
                  end else begin
                     ack_ok_s = 1'b0;
                  end
               end else begin
                  err_inc_s = 1'b1;
                  ack_ok_s  = 1'b0;
               end
               send_back_data_s = {seq_r, 1'b0, ack_ok_s, 6'b000000};
            end else if (type_r == TYPE_CTRL) begin
               if (sum_ok_s) begin
                  peer_statue_vaild_s = 1'b1;
                  peer_statue_s       = payload_r[31:16];
                  if (payload_r[3:0] == 4'h1) begin
                     send_info_vaild_s = 1'b1;
                     send_info_s       = payload_r[15:0];
                  end else begin
                     send_info_vaild_s = 1'b0;
                  end
               end else begin
                  err_inc_s = 1'b1;
               end
            end else begin
               err_inc_s = 1'b1;
            end

            // Back-to-back frames: a head in the check cycle starts the next frame.
            if (head_s) begin
               type_s  = gtp_rxdata[15:8];
               sum_s   = gtp_rxdata[23:16];
               seq_s   = gtp_rxdata[31:24];
               state_s = ST_PAYLOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (err_inc_s && (err_cnt_r != ERR_MAX)) begin
         err_cnt_s = err_cnt_r + ERR_ONE;
      end else begin
         err_cnt_s = err_cnt_r;
      end
   end

   // State, frame fields and registered outputs.
   always_ff @(posedge rx_clk) begin
      if (!ap_rst_n) begin
         state_r             <= ST_IDLE;
         type_r              <= 8'h00;
         sum_r               <= 8'h00;
         seq_r               <= 8'h00;
         payload_r           <= 32'h0000_0000;
         last_seq_r          <= 8'h00;
         last_seq_valid_r    <= 1'b0;
         rx_wren_r           <= 1'b0;
         rx_wrdata_r         <= 32'h0000_0000;
         send_back_flag_r    <= 1'b0;
         send_back_data_r    <= 16'h0000;
         send_info_vaild_r   <= 1'b0;
         send_info_r         <= 16'h0000;
         peer_statue_vaild_r <= 1'b0;
         peer_statue_r       <= 16'h0000;
         err_cnt_r           <= {ERR_CNT_W{1'b0}};
      end else begin
         state_r             <= state_s;
         type_r              <= type_s;
         sum_r               <= sum_s;
         seq_r               <= seq_s;
         payload_r           <= payload_s;
         last_seq_r          <= last_seq_s;
         last_seq_valid_r    <= last_seq_valid_s;
         rx_wren_r           <= rx_wren_s;
         rx_wrdata_r         <= rx_wrdata_s;
         send_back_flag_r    <= send_back_flag_s;
         send_back_data_r    <= send_back_data_s;
         send_info_vaild_r   <= send_info_vaild_s;
         send_info_r         <= send_info_s;
         peer_statue_vaild_r <= peer_statue_vaild_s;
         peer_statue_r       <= peer_statue_s;
         err_cnt_r           <= err_cnt_s;
      end
   end

   assign rx_wren           = rx_wren_r;
   assign rx_wrdata         = rx_wrdata_r;
   assign send_back_flag    = send_back_flag_r;
   assign send_back_data    = send_back_data_r;
   assign send_info_vaild   = send_info_vaild_r;
   assign send_info         = send_info_r;
   assign peer_statue_vaild = peer_statue_vaild_r;
   assign peer_statue       = peer_statue_r;
   assign err_cnt           = err_cnt_r;

endmodule

// File: tb/tb_recv_frame.sv
// Directed self-checking bench for recv_frame: hand-computed frames and expected outputs.

module tb_recv_frame;

   logic        rx_clk;
   logic        ap_rst_n;
   logic [31:0] gtp_rxdata;
   logic [3:0]  gtp_rxctl;
   logic        rx_allow;
   logic        rx_wren;
   logic [31:0] rx_wrdata;
   logic        send_back_flag;
   logic [15:0] send_back_data;
   logic        send_info_vaild;
   logic [15:0] send_info;
   logic        peer_statue_vaild;
   logic [15:0] peer_statue;
   logic [15:0] err_cnt;

   int tests_run;
   int tests_failed;

   recv_frame dut (
      .rx_clk            (rx_clk),
      .ap_rst_n          (ap_rst_n),
      .gtp_rxdata        (gtp_rxdata),
      .gtp_rxctl         (gtp_rxctl),
      .rx_allow          (rx_allow),
      .rx_wren           (rx_wren),
      .rx_wrdata         (rx_wrdata),
      .send_back_flag    (send_back_flag),
      .send_back_data    (send_back_data),
      .send_info_vaild   (send_info_vaild),
      .send_info         (send_info),
      .peer_statue_vaild (peer_statue_vaild),
      .peer_statue       (peer_statue),
      .err_cnt           (err_cnt)
   );

   initial begin
      rx_clk = 1'b0;
      forever #5 rx_clk = ~rx_clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One word per clock; returns 1 time unit after the capturing edge.
   task automatic drive(input logic [31:0] d, input logic [3:0] c);
      gtp_rxdata = d;
      gtp_rxctl  = c;
      @(posedge rx_clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic wr, input logic sb,
                              input logic iv, input logic pv);
      check_eq({tag, ".wren"},  32'(rx_wren),           32'(wr));
      check_eq({tag, ".sb"},    32'(send_back_flag),    32'(sb));
      check_eq({tag, ".info"},  32'(send_info_vaild),   32'(iv));
      check_eq({tag, ".peer"},  32'(peer_statue_vaild), 32'(pv));
   endtask

   task automatic frame(input string tag, input logic [31:0] head, input logic [31:0] payload,
                        input logic exp_wr, input logic exp_sb, input logic [15:0] exp_ack,
                        input logic exp_iv, input logic [15:0] exp_info,
                        input logic exp_pv, input logic [15:0] exp_peer,
                        input logic [15:0] exp_err);
      drive(head, 4'b0001);
      drive(payload, 4'b0000);
      check_eq({tag, ".early"}, 32'(rx_wren | send_back_flag | peer_statue_vaild), 32'd0);
      drive(32'h0000_0000, 4'b0000);
      check_flags(tag, exp_wr, exp_sb, exp_iv, exp_pv);
      if (exp_wr) check_eq({tag, ".wrdata"}, rx_wrdata, payload);
      if (exp_sb) check_eq({tag, ".ack"}, 32'(send_back_data), 32'(exp_ack));
      if (exp_iv) check_eq({tag, ".send_info"}, 32'(send_info), 32'(exp_info));
      if (exp_pv) check_eq({tag, ".peer_statue"}, 32'(peer_statue), 32'(exp_peer));
      check_eq({tag, ".err"}, 32'(err_cnt), 32'(exp_err));
      drive(32'h0000_0000, 4'b0000);
      check_flags({tag, ".clr"}, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      ap_rst_n     = 1'b0;
      rx_allow     = 1'b1;
      gtp_rxdata   = 32'h0000_0000;
      gtp_rxctl    = 4'b0000;
      repeat (3) @(posedge rx_clk);
      #1;
      check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset.err", 32'(err_cnt), 32'd0);
      check_eq("reset.wrdata", rx_wrdata, 32'd0);
      check_eq("reset.ack", 32'(send_back_data), 32'd0);
      ap_rst_n = 1'b1;
      drive(32'h0000_0000, 4'b0000);

      // tag, head, payload, wr, sb, ack, iv, info, pv, peer, err
      frame("good",  32'h01AC55BC, 32'h12345678, 1'b1, 1'b1, 16'h0140, 1'b0, 16'h0, 1'b0, 16'h0, 16'd0);
      frame("dup",   32'h01AC55BC, 32'h12345678, 1'b0, 1'b1, 16'h0140, 1'b0, 16'h0, 1'b0, 16'h0, 16'd0);
      frame("badsum",32'h02AD55BC, 32'h12345678, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0, 16'h0, 16'd1);
      rx_allow = 1'b0;
      frame("full",  32'h03AC55BC, 32'h12345678, 1'b0, 1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 16'h0, 16'd1);
      rx_allow = 1'b1;
      frame("retry", 32'h03AC55BC, 32'h12345678, 1'b1, 1'b1, 16'h0340, 1'b0, 16'h0, 1'b0, 16'h0, 16'd1);
      frame("back",  32'h07E6AABC, 32'h00A50241, 1'b0, 1'b0, 16'h0,    1'b1, 16'h0241, 1'b1, 16'h00A5, 16'd1);
      frame("status",32'h0AF5AABC, 32'h00B50240, 1'b0, 1'b0, 16'h0,    1'b0, 16'h0, 1'b1, 16'h00B5, 16'd1);
      frame("ctlbad",32'h09E7AABC, 32'h00A50241, 1'b0, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 16'd2);
      frame("unk",   32'h08AC33BC, 32'h12345678, 1'b0, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 16'd3);

      // A second head replaces the first; only seq 0x05 is written.
      drive(32'h04AC55BC, 4'b0001);
      frame("rehead",32'h05AC55BC, 32'h12345678, 1'b1, 1'b1, 16'h0540, 1'b0, 16'h0, 1'b0, 16'h0, 16'd4);

      // Non-head control word aborts to idle; the later data word is ignored.
      drive(32'h0BAC55BC, 4'b0001);
      drive(32'h12345678, 4'b0010);
      drive(32'h12345678, 4'b0000);
      drive(32'h0000_0000, 4'b0000);
      check_flags("ctlabort", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("ctlabort.err", 32'(err_cnt), 32'd5);

      // Back-to-back frames: second head lands in the check cycle.
      drive(32'h0C3355BC, 4'b0001);
      drive(32'hA0110022, 4'b0000);
      drive(32'h0D6755BC, 4'b0001);
      check_flags("b2b0", 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("b2b0.wrdata", rx_wrdata, 32'hA0110022);
      check_eq("b2b0.ack", 32'(send_back_data), 32'h0C40);
      drive(32'h5566FF01, 4'b0000);
      check_flags("b2b.gap", 1'b0, 1'b0, 1'b0, 1'b0);
      drive(32'h0000_0000, 4'b0000);
      check_flags("b2b1", 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("b2b1.wrdata", rx_wrdata, 32'h5566FF01);
      check_eq("b2b1.ack", 32'(send_back_data), 32'h0D40);
      check_eq("b2b1.err", 32'(err_cnt), 32'd5);
      drive(32'h0000_0000, 4'b0000);

      // Sequence wrap 0xFF -> 0x00 is a new frame; FF+FF truncates to FE.
      frame("seqff", 32'hFFFE55BC, 32'h00FF00FF, 1'b1, 1'b1, 16'hFF40, 1'b0, 16'h0, 1'b0, 16'h0, 16'd5);
      frame("seq00", 32'h00AC55BC, 32'h12345678, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 16'd5);

      // Reset between head and payload discards the frame.
      drive(32'h0EAC55BC, 4'b0001);
      ap_rst_n = 1'b0;
      drive(32'h0000_0000, 4'b0000);
      ap_rst_n = 1'b1;
      drive(32'h12345678, 4'b0000);
      drive(32'h0000_0000, 4'b0000);
      check_flags("rstmid", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rstmid.err", 32'(err_cnt), 32'd0);
      drive(32'h0000_0000, 4'b0000);
      check_flags("rstmid2", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
